// File: rtl/window_sched.sv
// window_sched: trial controller that gates samples into window_gen and triggers window readouts.
// Optional macro WINDOW_SCHED_STATS_EN adds the stall_cycles statistics output.
module window_sched #(
    parameter int DATA_WIDTH        = 16,
    parameter int WINDOW_SIZE       = 32,
    parameter int HOP               = 8,
    parameter int WINDOWS_PER_TRIAL = 16,
    localparam int CNT_W  = $clog2(WINDOW_SIZE + 1),
    localparam int WIDX_W = $clog2(WINDOWS_PER_TRIAL) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic signed [DATA_WIDTH-1:0] s_sample,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] gen_sample,
    output logic                         gen_valid,
    output logic                         read_trig,
    output logic [WIDX_W-1:0]            win_idx,
    output logic                         busy,
    output logic                         trial_done
`ifdef WINDOW_SCHED_STATS_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    if (HOP < 1 || HOP > WINDOW_SIZE) begin : g_bad_hop
        $error("window_sched: HOP must be in 1..WINDOW_SIZE");
    end
    if (WINDOWS_PER_TRIAL < 1) begin : g_bad_wpt
        $error("window_sched: WINDOWS_PER_TRIAL must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_HOP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  smp_q, smp_d;
    logic [CNT_W-1:0]  rd_q, rd_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    assign s_ready    = (state_q == S_FILL) || (state_q == S_HOP);
    assign accept     = s_valid & s_ready;
    assign gen_valid  = accept;
    assign gen_sample = s_sample;
    assign read_trig  = trig_q;
    assign win_idx    = widx_q;
    assign busy       = busy_q;
    assign trial_done = done_q;

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        rd_d    = rd_q;
        widx_d  = widx_q;
        trig_d  = 1'b0;
        // abort beats every transition, including the final accept or read cycle
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            smp_d   = '0;
            rd_d    = '0;
            widx_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_FILL;
                        smp_d   = '0;
                        rd_d    = '0;
                        widx_d  = '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        if (smp_q == CNT_W'(WINDOW_SIZE - 1)) begin
                            state_d = S_READ;
                            smp_d   = '0;
                            rd_d    = '0;
                            trig_d  = 1'b1;
                        end else begin
                            smp_d = smp_q + CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (rd_q == CNT_W'(WINDOW_SIZE - 1)) begin
                        rd_d = '0;
                        if (widx_q == WIDX_W'(WINDOWS_PER_TRIAL - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            widx_d  = widx_q + WIDX_W'(1);
                            state_d = S_HOP;
                        end
                    end else begin
                        rd_d = rd_q + CNT_W'(1);
                    end
                end
                S_HOP: begin
                    if (accept) begin
                        if (smp_q == CNT_W'(HOP - 1)) begin
                            state_d = S_READ;
                            smp_d   = '0;
                            rd_d    = '0;
                            trig_d  = 1'b1;
                        end else begin
                            smp_d = smp_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            smp_q   <= '0;
            rd_q    <= '0;
            widx_q  <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            rd_q    <= rd_d;
            widx_q  <= widx_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef WINDOW_SCHED_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start && !abort) begin
            stall_d = '0;
        end else if (busy_q && s_valid && !s_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_window_sched.sv
// Directed table-driven bench for window_sched (WINDOW_SIZE=4, HOP=2, WINDOWS_PER_TRIAL=3).
// Stall counter checks are active when WINDOW_SCHED_STATS_EN is defined.
module tb_window_sched;

    localparam int DW  = 16;
    localparam int WS  = 4;
    localparam int HP  = 2;
    localparam int WPT = 3;
    localparam int WW  = $clog2(WPT) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic signed [DW-1:0] s_sample;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] gen_sample;
    logic                 gen_valid;
    logic                 read_trig;
    logic [WW-1:0]        win_idx;
    logic                 busy;
    logic                 trial_done;
`ifdef WINDOW_SCHED_STATS_EN
    logic [31:0]          stall_cycles;
`endif

    window_sched #(
        .DATA_WIDTH       (DW),
        .WINDOW_SIZE      (WS),
        .HOP              (HP),
        .WINDOWS_PER_TRIAL(WPT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .s_sample  (s_sample),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .gen_sample(gen_sample),
        .gen_valid (gen_valid),
        .read_trig (read_trig),
        .win_idx   (win_idx),
        .busy      (busy),
        .trial_done(trial_done)
`ifdef WINDOW_SCHED_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          abort;
        logic          rst;
        logic          valid;
        logic          e_ready;
        logic          e_trig;
        logic          e_busy;
        logic          e_done;
        logic [WW-1:0] e_widx;
        int            e_stall;
    } vec_t;

    vec_t tbl[$];
    int   ntests = 0;
    int   nfail  = 0;

    // Hand-derived nominal schedule, c = cycles after the start pulse.
    function automatic vec_t nom(input int c, input logic [WW-1:0] prev_widx);
        vec_t v;
        v.start   = (c == 0);
        v.abort   = 1'b0;
        v.rst     = 1'b0;
        v.valid   = 1'b1;
        v.e_ready = (c >= 1 && c <= 4) || (c >= 9 && c <= 10) || (c >= 15 && c <= 16);
        v.e_trig  = (c == 5) || (c == 11) || (c == 17);
        v.e_busy  = (c >= 1 && c <= 21);
        v.e_done  = (c == 21);
        if (c == 0)       v.e_widx = prev_widx;
        else if (c <= 8)  v.e_widx = 0;
        else if (c <= 14) v.e_widx = 1;
        else              v.e_widx = 2;
        v.e_stall = -1;
        return v;
    endfunction

    function automatic vec_t idle_vec(input logic [WW-1:0] w);
        vec_t v;
        v.start   = 1'b0;
        v.abort   = 1'b0;
        v.rst     = 1'b0;
        v.valid   = 1'b1;
        v.e_ready = 1'b0;
        v.e_trig  = 1'b0;
        v.e_busy  = 1'b0;
        v.e_done  = 1'b0;
        v.e_widx  = w;
        v.e_stall = -1;
        return v;
    endfunction

    task automatic run(input string name);
        foreach (tbl[i]) begin
            start    = tbl[i].start;
            abort    = tbl[i].abort;
            rst      = tbl[i].rst;
            s_valid  = tbl[i].valid;
            s_sample = DW'($urandom);
            @(negedge clk);
            ntests++;
            if (s_ready !== tbl[i].e_ready || read_trig !== tbl[i].e_trig ||
                busy !== tbl[i].e_busy || trial_done !== tbl[i].e_done ||
                win_idx !== tbl[i].e_widx ||
                gen_valid !== (tbl[i].e_ready & tbl[i].valid) ||
                gen_sample !== s_sample) begin
                nfail++;
                $display("FAIL %s[%0d]: got rdy=%b gv=%b trig=%b widx=%0d busy=%b done=%b smp=%h, want rdy=%b gv=%b trig=%b widx=%0d busy=%b done=%b smp=%h",
                         name, i, s_ready, gen_valid, read_trig, win_idx, busy, trial_done, gen_sample,
                         tbl[i].e_ready, tbl[i].e_ready & tbl[i].valid, tbl[i].e_trig,
                         tbl[i].e_widx, tbl[i].e_busy, tbl[i].e_done, s_sample);
            end
`ifdef WINDOW_SCHED_STATS_EN
            if (tbl[i].e_stall >= 0) begin
                ntests++;
                if (stall_cycles !== 32'(tbl[i].e_stall)) begin
                    nfail++;
                    $display("FAIL %s[%0d] stall_cycles: got %0d, want %0d",
                             name, i, stall_cycles, tbl[i].e_stall);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        tbl.delete();
    endtask

    initial begin
        vec_t v;
        int   acc, trigs, dones, viol, cyc;
        logic [3*WW-1:0] widx_seen;
        logic            ok;

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        s_valid  = 1'b1;
        s_sample = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ntests++;
        if ({s_ready, gen_valid, read_trig, busy, trial_done} !== 5'b0 || win_idx !== '0) begin
            nfail++;
            $display("FAIL reset: got rdy=%b gv=%b trig=%b busy=%b done=%b widx=%0d, want all 0",
                     s_ready, gen_valid, read_trig, busy, trial_done, win_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c <= 22; c++) begin
            v = nom(c, 0);
            if (c == 21) v.e_stall = 12;
            tbl.push_back(v);
        end
        run("nominal");

        for (int c = 0; c <= 22; c++) begin
            v = nom(c, 2);
            if (c == 6) v.start = 1'b1;
            if (c == 1) v.e_stall = 0;
            if (c == 21) v.e_stall = 12;
            tbl.push_back(v);
        end
        run("start_in_read");

        v = idle_vec(2);
        v.start = 1'b1;
        v.abort = 1'b1;
        tbl.push_back(v);
        tbl.push_back(idle_vec(2));
        tbl.push_back(idle_vec(2));
        run("start_abort_idle");

        for (int c = 0; c <= 12; c++) begin
            v = nom(c, 2);
            if (c == 12) v.abort = 1'b1;
            tbl.push_back(v);
        end
        for (int c = 13; c <= 24; c++) tbl.push_back(idle_vec(0));
        run("abort_read");

        for (int c = 0; c <= 22; c++) tbl.push_back(nom(c, 0));
        run("restart");

        for (int c = 0; c <= 10; c++) begin
            v = nom(c, 2);
            if (c == 10) v.rst = 1'b1;
            tbl.push_back(v);
        end
        v = idle_vec(0);
        v.e_stall = 0;
        tbl.push_back(v);
        for (int c = 12; c <= 34; c++) tbl.push_back(nom(c - 12, 0));
        run("mid_reset");

        // Sparse input: one valid every third cycle.
        acc = 0;
        trigs = 0;
        dones = 0;
        viol = 0;
        cyc = 0;
        widx_seen = '0;
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (dones == 0 && cyc < 300) begin
            s_valid  = (cyc % 3 == 0);
            s_sample = DW'($urandom);
            @(negedge clk);
            if (gen_valid !== (s_valid & s_ready)) viol++;
            if (gen_valid === 1'b1 && s_ready !== 1'b1) viol++;
            if (gen_valid === 1'b1) acc++;
            if (read_trig === 1'b1) begin
                if (trigs < 3) widx_seen[trigs*WW +: WW] = win_idx;
                trigs++;
            end
            if (trial_done === 1'b1) dones++;
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (3) begin
            s_valid = (cyc % 3 == 0);
            @(negedge clk);
            if (trial_done === 1'b1) dones++;
            if (gen_valid === 1'b1) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end

        ntests++;
        if (cyc >= 300) begin
            nfail++;
            $display("FAIL sparse_timeout: got no trial_done within %0d cycles, want one", cyc);
        end
        ntests++;
        if (acc != 8) begin
            nfail++;
            $display("FAIL sparse_accepts: got %0d, want 8", acc);
        end
        ntests++;
        if (trigs != 3) begin
            nfail++;
            $display("FAIL sparse_trigs: got %0d, want 3", trigs);
        end
        ntests++;
        if (dones != 1) begin
            nfail++;
            $display("FAIL sparse_done: got %0d, want 1", dones);
        end
        ntests++;
        ok = (widx_seen[0 +: WW] == 0) && (widx_seen[WW +: WW] == 1) && (widx_seen[2*WW +: WW] == 2);
        if (!ok) begin
            nfail++;
            $display("FAIL sparse_widx: got %h, want windows 0,1,2", widx_seen);
        end
        ntests++;
        if (viol != 0) begin
            nfail++;
            $display("FAIL sparse_gating: got %0d bad accepts, want 0", viol);
        end
        @(negedge clk);
        ntests++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL sparse_idle: got busy=%b, want 0", busy);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
